// File: rtl/display_pkg.sv
// Shared types and constants for the result display: digit count, blank
// pattern and the active-low hex-to-segment table.
package display_pkg;

    localparam int DIGITS = 4;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    // Segment order {g,f,e,d,c,b,a}, active-low; entry 15 first.
    localparam logic [15:0][6:0] HEX7_TAB = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef struct packed {
        logic       vld;
        logic [3:0] val;
    } slot_t;

    function automatic seg_t hex7(input logic [3:0] v);
        return HEX7_TAB[v];
    endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex digit to active-low seven-segment decoder.
module hex_to_7seg
    import display_pkg::*;
(
    input  logic [3:0] hex,
    output seg_t       seg
);

    assign seg = hex7(hex);

endmodule

// File: rtl/result_display.sv
// Captures solution on each dv rising edge into a 4-deep newest-first history
// and scans it onto four active-low seven-segment digits.
module result_display
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] solution,
    input  logic       dv,
    input  logic       hold,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic [7:0] result_cnt
);

    localparam int DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);

    slot_t [DIGITS-1:0] hist;
    logic [DW-1:0]      div;
    logic [1:0]         idx;
    logic               dv_q;
    logic               new_res;
    slot_t              cur;
    seg_t               dec_seg;

    // dv_q follows dv even under hold, so an edge swallowed by hold is gone.
    assign new_res = dv & ~dv_q & ~hold;
    assign cur     = hist[idx];

    hex_to_7seg u_dec (
        .hex (cur.val),
        .seg (dec_seg)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            hist       <= '0;
            div        <= '0;
            idx        <= '0;
            dv_q       <= 1'b0;
            result_cnt <= '0;
            seg        <= SEG_BLANK;
            an         <= 4'hF;
        end else begin
            dv_q <= dv;

            if (new_res) begin
                hist <= {hist[DIGITS-2:0], {1'b1, solution}};
                if (result_cnt != 8'hFF)
                    result_cnt <= result_cnt + 8'd1;
            end

            if (div == DIV_LAST) begin
                div <= '0;
                idx <= idx + 2'd1;
            end else begin
                div <= div + 1'b1;
            end

            // Outputs use pre-update idx/history: one cycle of display latency.
            an  <= ~(4'b0001 << idx);
            seg <= cur.vld ? dec_seg : SEG_BLANK;
        end
    end

endmodule

// File: tb/tb_result_display.sv
// Scoreboard bench for result_display: stimulus queues expected digit
// contents, a monitor matches them against the scanned outputs.
module tb_result_display;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] solution;
    logic       dv;
    logic       hold;
    logic [6:0] seg, seg1;
    logic [3:0] an, an1;
    logic [7:0] result_cnt, cnt1;

    always #5 clk = ~clk;

    result_display #(.REFRESH_DIV(4)) dut (
        .clk(clk), .reset(reset), .solution(solution), .dv(dv), .hold(hold),
        .seg(seg), .an(an), .result_cnt(result_cnt)
    );

    result_display #(.REFRESH_DIV(1)) dut1 (
        .clk(clk), .reset(reset), .solution(solution), .dv(dv), .hold(hold),
        .seg(seg1), .an(an1), .result_cnt(cnt1)
    );

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic [7:0] cnt;
        int         tag;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   have  = 0;
    int   tag   = 0;

    task automatic check(input string nm, input int t, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s tag=%0d: got %0h want %0h", nm, t, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] a, input logic [6:0] s, input logic [7:0] c);
        exp_t e;
        e.an = a; e.seg = s; e.cnt = c; e.tag = tag;
        tag++;
        q.push_back(e);
    endtask

    task automatic push4(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                         input logic [6:0] s3, input logic [7:0] c);
        push(4'b1110, s0, c);
        push(4'b1101, s1, c);
        push(4'b1011, s2, c);
        push(4'b0111, s3, c);
    endtask

    task automatic drain();
        int t = 0;
        while ((q.size() > 0 || have) && t < 400) begin
            @(posedge clk);
            t++;
        end
        if (t >= 400) check("drain_timeout", tag, 1, 0);
        #1;
    endtask

    task automatic pulse(input logic [3:0] v);
        @(posedge clk); #1;
        solution = v;
        dv       = 1'b1;
        @(posedge clk); #1;
        dv       = 1'b0;
    endtask

    task automatic settle();
        @(posedge clk); #1;
    endtask

    // Monitor: match queued expectations, check dwell and scan order.
    initial begin
        exp_t       cur;
        int         waitc   = 0;
        int         dwell   = 0;
        logic [3:0] last_an = 4'hF;
        logic [3:0] last_an1 = 4'hF;
        forever begin
            @(negedge clk);
            if (!have && q.size() > 0) begin
                cur   = q.pop_front();
                have  = 1;
                waitc = 0;
            end
            if (have) begin
                if (an === cur.an && (cur.an == 4'hF || last_an !== cur.an)) begin
                    check("seg", cur.tag, 32'(seg), 32'(cur.seg));
                    check("result_cnt", cur.tag, 32'(result_cnt), 32'(cur.cnt));
                    have = 0;
                end else if (++waitc > 80) begin
                    check("an_wait_timeout", cur.tag, 32'(an), 32'(cur.an));
                    have = 0;
                end
            end
            if (an !== last_an) begin
                if (!$isunknown(an) && last_an != 4'hF && an != 4'hF) begin
                    check("dwell", 0, dwell, 4);
                    check("scan_order", 0, 32'(an), 32'({last_an[2:0], last_an[3]}));
                end
                dwell = 1;
            end else begin
                dwell++;
            end
            last_an = an;
            if (!$isunknown(an1) && last_an1 != 4'hF && an1 != 4'hF)
                check("div1_scan", 0, 32'(an1), 32'({last_an1[2:0], last_an1[3]}));
            last_an1 = an1;
        end
    end

    initial begin
        reset = 1'b1; dv = 1'b0; hold = 1'b0; solution = 4'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (7) @(posedge clk);
        #1;

        // Reset mid-scan, then blank scan from digit 0.
        reset = 1'b1;
        push(4'hF, 7'h7F, 8'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        push4(7'h7F, 7'h7F, 7'h7F, 7'h7F, 8'd0);
        drain();

        // Single capture.
        pulse(4'h5);
        settle();
        push4(7'h12, 7'h7F, 7'h7F, 7'h7F, 8'd1);
        drain();

        // History overflow.
        pulse(4'h1); pulse(4'h2); pulse(4'h3); pulse(4'h4); pulse(4'h9);
        settle();
        push4(7'h10, 7'h19, 7'h30, 7'h24, 8'd6);
        drain();

        // Level dv: only the rising cycle's value is captured.
        @(posedge clk); #1;
        solution = 4'h7;
        dv       = 1'b1;
        for (int i = 0; i < 19; i++) begin
            @(posedge clk); #1;
            solution = 4'(i);
        end
        @(posedge clk); #1;
        dv = 1'b0;
        settle();
        push4(7'h78, 7'h10, 7'h19, 7'h30, 8'd7);
        drain();

        // Edge lost under hold.
        hold = 1'b1;
        pulse(4'hF);
        hold = 1'b0;
        settle();
        push4(7'h78, 7'h10, 7'h19, 7'h30, 8'd7);
        drain();

        // dv still high when hold drops: no capture.
        hold = 1'b1; dv = 1'b1; solution = 4'hA;
        settle(); settle();
        hold = 1'b0;
        settle(); settle();
        dv = 1'b0;
        settle();
        push4(7'h78, 7'h10, 7'h19, 7'h30, 8'd7);
        drain();

        // Capture after hold released.
        pulse(4'hF);
        settle();
        push4(7'h0E, 7'h78, 7'h10, 7'h19, 8'd8);
        drain();

        // Saturation.
        for (int i = 0; i < 260; i++) pulse(4'(i));
        settle();
        push4(7'h30, 7'h24, 7'h79, 7'h40, 8'd255);
        drain();

        // Reset wins over a same-cycle dv edge.
        @(posedge clk); #1;
        reset = 1'b1; dv = 1'b1; solution = 4'h5;
        push(4'hF, 7'h7F, 8'd0);
        @(posedge clk); #1;
        reset = 1'b0; dv = 1'b0;
        push4(7'h7F, 7'h7F, 7'h7F, 7'h7F, 8'd0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
